// File: rtl/prewish_pkg.sv
// prewish_pkg: mode codes and FSM states shared by the mask sequencer and its bench-facing users
package prewish_pkg;
    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_AUTO = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_ONCE = 2'b11;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OFFER = 2'b01,
        ST_DONE  = 2'b10
    } state_t;
endpackage

// File: rtl/prewish_prescaler.sv
// prewish_prescaler: modulo-PERIOD counter with synchronous clear and a one-cycle tick at PERIOD-1
// Ports: clk_i clock, rst_ni async active-low reset, clr_i holds the count at zero, tick_o terminal-count pulse.
module prewish_prescaler #(
    parameter int unsigned PERIOD = 24'd12_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);
    localparam int unsigned CW = $clog2(PERIOD);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        tick_o = !clr_i && cnt_q == CW'(PERIOD - 1);
        cnt_d  = (clr_i || tick_o) ? '0 : cnt_q + CW'(1);
    end
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
endmodule

// File: rtl/prewish_mask_sequencer.sv
// prewish_mask_sequencer: writable mask table emitted one entry at a time over STB/ACK
// Ports: CLK_I/RST_I clock and async active-low reset; MODE_I halt/auto/step/once; LEN_I active length;
// STEP_I manual trigger; WE_I/ADR_I/WDAT_I table write; STB_O/DAT_O/ACK_I mask handshake;
// IDX_O next index; BUSY_O mirrors STB_O; DONE_O one-shot pass complete; OVR_O sticky dropped trigger.
module prewish_mask_sequencer
    import prewish_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned AW     = $clog2(DEPTH),
    parameter int unsigned PERIOD = 24'd12_000_000
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic [1:0]        MODE_I,
    input  logic [AW:0]       LEN_I,
    input  logic              STEP_I,
    input  logic              WE_I,
    input  logic [AW-1:0]     ADR_I,
    input  logic [DATA_W-1:0] WDAT_I,
    output logic              STB_O,
    output logic [DATA_W-1:0] DAT_O,
    input  logic              ACK_I,
    output logic [AW-1:0]     IDX_O,
    output logic              BUSY_O,
    output logic              DONE_O,
    output logic              OVR_O
);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] tbl_q [DEPTH];
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [AW-1:0]     idx_q, idx_d, ridx, nidx;
    logic [AW:0]       len_eff;
    logic [1:0]        mode_q;
    logic              once_q, once_d, done_q, done_d, ovr_q, ovr_d;
    logic              tick, trig, wrap;

    prewish_prescaler #(.PERIOD(PERIOD)) u_presc (
        .clk_i (CLK_I),
        .rst_ni(RST_I),
        .clr_i (MODE_I != MODE_AUTO),
        .tick_o(tick)
    );

    always_comb begin
        len_eff = (LEN_I == '0) ? (AW+1)'(1) : (LEN_I > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : LEN_I;
        // a shrunken LEN_I restarts the sequence from entry 0
        ridx    = ({1'b0, idx_q} >= len_eff) ? '0 : idx_q;
        wrap    = {1'b0, idx_q} + (AW+1)'(1) == len_eff;
        nidx    = wrap ? '0 : idx_q + AW'(1);
        // once_q carries the "next entry of the pass" request into the IDLE cycle after an ACK
        trig    = (MODE_I == MODE_AUTO && tick) || (MODE_I == MODE_STEP && STEP_I) ||
                  (MODE_I == MODE_ONCE && (mode_q != MODE_ONCE || once_q));
    end

    always_comb begin
        state_d = state_q;
        dat_d   = dat_q;
        idx_d   = idx_q;
        once_d  = 1'b0;
        done_d  = 1'b0;
        ovr_d   = (MODE_I == MODE_HALT && mode_q != MODE_HALT) ? 1'b0 : ovr_q;
        if (trig && state_q != ST_IDLE) ovr_d = 1'b1;
        case (state_q)
            ST_IDLE: if (trig) begin
                dat_d   = tbl_q[ridx];
                idx_d   = ridx;
                state_d = ST_OFFER;
            end
            ST_OFFER: if (ACK_I) begin
                idx_d   = nidx;
                state_d = (MODE_I == MODE_ONCE && wrap) ? ST_DONE : ST_IDLE;
                done_d  = MODE_I == MODE_ONCE && wrap;
                once_d  = MODE_I == MODE_ONCE && !wrap;
            end
            ST_DONE: if (MODE_I != MODE_ONCE) begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I)
        if (!RST_I) begin
            state_q <= ST_IDLE;
            dat_q   <= '0;
            idx_q   <= '0;
            mode_q  <= MODE_HALT;
            once_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            idx_q   <= idx_d;
            mode_q  <= MODE_I;
            once_q  <= once_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end

    // the read for a trigger happens combinationally before this edge, so a same-cycle write is not seen
    always_ff @(posedge CLK_I or negedge RST_I)
        if (!RST_I) for (int i = 0; i < int'(DEPTH); i++) tbl_q[i] <= '0;
        else if (WE_I) tbl_q[ADR_I] <= WDAT_I;

    assign STB_O  = state_q == ST_OFFER;
    assign BUSY_O = STB_O;
    assign DAT_O  = dat_q;
    assign IDX_O  = idx_q;
    assign DONE_O = done_q;
    assign OVR_O  = ovr_q;
endmodule

// File: tb/tb_prewish_mask_sequencer.sv
// tb_prewish_mask_sequencer: directed test-plan steps plus randomized traffic against a behavioural model
module tb_prewish_mask_sequencer;
    localparam int DW = 8, DEPTH = 8, AW = 3, P = 8;

    logic          clk = 1'b0, rst_n;
    logic [1:0]    mode;
    logic [AW:0]   len;
    logic          step, we, ack;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    logic          stb, busy, done, ovr;
    logic [DW-1:0] dat;
    logic [AW-1:0] idx;
    int            checks = 0, failures = 0;

    logic [DW-1:0] m_tab [DEPTH];
    logic [DW-1:0] m_dat;
    logic          m_offer, m_done, m_pulse, m_ovr, m_cont;
    logic [1:0]    m_prev;
    int            m_idx, m_nauto;

    logic [DW-1:0] tv [DEPTH];
    logic [DW-1:0] exp_auto [4];
    int            held, nstb, ndone;

    always #5 clk = ~clk;

    prewish_mask_sequencer #(.DATA_W(DW), .DEPTH(DEPTH), .PERIOD(P)) dut (
        .CLK_I(clk), .RST_I(rst_n), .MODE_I(mode), .LEN_I(len), .STEP_I(step),
        .WE_I(we), .ADR_I(adr), .WDAT_I(wdat), .STB_O(stb), .DAT_O(dat), .ACK_I(ack),
        .IDX_O(idx), .BUSY_O(busy), .DONE_O(done), .OVR_O(ovr)
    );

    function automatic int len_eff(input int l);
        return l == 0 ? 1 : (l > DEPTH ? DEPTH : l);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".stb"},  32'(stb),  32'(m_offer));
        chk({tag, ".busy"}, 32'(busy), 32'(m_offer));
        chk({tag, ".dat"},  32'(dat),  32'(m_dat));
        chk({tag, ".idx"},  32'(idx),  32'(m_idx));
        chk({tag, ".done"}, 32'(done), 32'(m_pulse));
        chk({tag, ".ovr"},  32'(ovr),  32'(m_ovr));
    endtask

    task automatic mdl_reset();
        foreach (m_tab[i]) m_tab[i] = '0;
        m_dat = '0; m_offer = 0; m_done = 0; m_pulse = 0; m_ovr = 0; m_cont = 0;
        m_prev = 2'b00; m_idx = 0; m_nauto = 0;
    endtask

    // One clock of the specified behaviour, evaluated on the inputs present before the edge.
    task automatic mdl_step();
        int le, i, n;
        logic trig, cont, pulse;
        n     = (mode == 2'b01) ? m_nauto + 1 : 0;
        trig  = (mode == 2'b01 && n % P == 0) || (mode == 2'b10 && step) ||
                (mode == 2'b11 && (m_prev != 2'b11 || m_cont));
        le    = len_eff(int'(len));
        cont  = 0;
        pulse = 0;
        if (mode == 2'b00 && m_prev != 2'b00) m_ovr = 0;
        if (trig && (m_offer || m_done)) m_ovr = 1;
        if (m_offer) begin
            if (ack) begin
                m_offer = 0;
                if (m_idx + 1 == le && mode == 2'b11) begin m_done = 1; pulse = 1; end
                else cont = (mode == 2'b11);
                m_idx = (m_idx + 1 == le) ? 0 : (m_idx + 1) % DEPTH;
            end
        end else if (m_done) begin
            if (mode != 2'b11) begin m_done = 0; m_idx = 0; end
        end else if (trig) begin
            i = (m_idx >= le) ? 0 : m_idx;
            m_dat = m_tab[i]; m_idx = i; m_offer = 1;
        end
        if (we) m_tab[adr] = wdat;
        m_prev = mode; m_cont = cont; m_pulse = pulse; m_nauto = n;
    endtask

    task automatic tick();
        mdl_step();
        @(posedge clk);
        #1;
        cmp_all("cyc");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mdl_reset();
        mode = 2'b00; len = '0; step = 0; we = 0; ack = 0; adr = '0; wdat = '0;
        #2 cmp_all("rst");
        @(posedge clk);
        #1 cmp_all("rst_hold");
        rst_n = 1'b1;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        we = 1; adr = AW'(a); wdat = d;
        tv[a] = d;
        tick();
        we = 0;
    endtask

    initial begin
        rst_n = 1'b1;
        #1 do_reset();

        // auto mode: period 8, length 3, ACK tied high
        exp_auto[0] = 8'h80; exp_auto[1] = 8'hA0; exp_auto[2] = 8'hA8; exp_auto[3] = 8'h80;
        wr(0, 8'h80); wr(1, 8'hA0); wr(2, 8'hA8);
        len = 4'd3; ack = 1; mode = 2'b01;
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (c % 8 == 0) begin
                chk("auto_stb", 32'(stb), 32'd1);
                chk("auto_dat", 32'(dat), 32'(exp_auto[c/8-1]));
            end else chk("auto_quiet", 32'(stb), 32'd0);
        end
        mode = 2'b00; tick();

        // manual step, ACK late, overlapping second step
        do_reset();
        mode = 2'b10; len = 4'd3; ack = 0; held = 0;
        step = 1; tick(); held += int'(stb);
        chk("man_rise", 32'(stb), 32'd1);
        step = 0; tick(); held += int'(stb);
        step = 1; tick(); held += int'(stb);
        step = 0; tick(); held += int'(stb);
        tick(); held += int'(stb);
        ack = 1; tick(); held += int'(stb);
        ack = 0;
        chk("man_held", 32'(held), 32'd5);
        chk("man_ovr", 32'(ovr), 32'd1);
        chk("man_idx", 32'(idx), 32'd1);
        chk("man_fall", 32'(stb), 32'd0);

        // one-shot pass of length 2
        do_reset();
        wr(0, 8'hFF); wr(1, 8'hD4);
        len = 4'd2; ack = 1; mode = 2'b11; nstb = 0; ndone = 0;
        tick();
        chk("once_first", 32'(dat), 32'hFF);
        for (int c = 0; c < 16; c++) begin
            nstb += int'(stb); ndone += int'(done);
            tick();
        end
        chk("once_xfers", 32'(nstb), 32'd2);
        chk("once_done", 32'(ndone), 32'd1);
        mode = 2'b00; tick();
        mode = 2'b11; tick();
        chk("once_again_stb", 32'(stb), 32'd1);
        chk("once_again_dat", 32'(dat), 32'hFF);

        // async reset in the middle of an offer, then table reads back zero
        do_reset();
        for (int i = 0; i < DEPTH; i++) wr(i, DW'($urandom_range(1, 255)));
        mode = 2'b10; len = 4'd8; ack = 0;
        step = 1; tick(); step = 0;
        chk("offer_before_rst", 32'(stb), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_stb", 32'(stb), 32'd0);
        chk("arst_dat", 32'(dat), 32'd0);
        chk("arst_idx", 32'(idx), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ovr", 32'(ovr), 32'd0);
        do_reset();
        mode = 2'b10; len = 4'd8; ack = 1;
        for (int i = 0; i < DEPTH; i++) begin
            step = 1; tick(); step = 0;
            chk("tbl_zero", 32'(dat), 32'd0);
            tick();
        end

        // LEN shrink below the current index
        do_reset();
        for (int i = 0; i < DEPTH; i++) wr(i, DW'($urandom_range(0, 255)));
        mode = 2'b10; len = 4'd8; ack = 1;
        for (int i = 0; i < 5; i++) begin step = 1; tick(); step = 0; tick(); end
        chk("shrink_idx5", 32'(idx), 32'd5);
        len = 4'd2;
        step = 1; tick(); step = 0;
        chk("shrink_dat", 32'(dat), 32'(tv[0]));
        tick();
        chk("shrink_idx", 32'(idx), 32'd1);

        // write and trigger on the same entry in the same cycle
        do_reset();
        wr(0, 8'h3C); wr(1, 8'h5A);
        mode = 2'b10; len = 4'd2; ack = 1;
        step = 1; we = 1; adr = '0; wdat = 8'hC3; tick(); step = 0; we = 0;
        chk("wr_old", 32'(dat), 32'h3C);
        tick();
        step = 1; tick(); step = 0; tick();
        step = 1; tick(); step = 0;
        chk("wr_new", 32'(dat), 32'hC3);
        tick();

        // randomized traffic against the model
        do_reset();
        for (int k = 0; k < 800; k++) begin
            if (k % 24 == 0) mode = 2'($urandom_range(0, 3));
            if (k % 37 == 0) len = 4'($urandom_range(0, 15));
            step = ($urandom_range(0, 3) == 0);
            ack  = ($urandom_range(0, 1) == 1);
            we   = ($urandom_range(0, 4) == 0);
            adr  = AW'($urandom_range(0, 7));
            wdat = DW'($urandom_range(0, 255));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prewish_mask_sequencer.md
# prewish_mask_sequencer

Parametrised mask source that feeds the blink mentor. It holds a writable table of blink masks and emits them one at a time over a strobe/acknowledge handshake. Emission is driven by a programmable period, a manual step pulse, or a single pass through the table. It sits between the board-level controller (which owns the buttons and DIP switches) and the mentor's STB/DAT input.

## Interface
Parameters:
- DATA_W, 8, mask width in bits
- DEPTH, 8, table entries; power of two, ≥2
- AW, $clog2(DEPTH), table address width (derived, do not override)
- PERIOD, 24'd12_000_000, auto-mode interval in CLK_I cycles; ≥4

Ports:
- CLK_I  in  1  system clock
- RST_I  in  1  asynchronous, active-low reset
- MODE_I  in  2  00 halt, 01 auto, 10 manual step, 11 one-shot
- LEN_I  in  AW+1  active sequence length, 1..DEPTH; 0 is treated as 1, values >DEPTH as DEPTH
- STEP_I  in  1  single-cycle step request (manual mode), already debounced
- WE_I  in  1  table write enable
- ADR_I  in  AW  table write address
- WDAT_I  in  DATA_W  table write data
- STB_O  out  1  mask valid; held until acknowledged
- DAT_O  out  DATA_W  mask being offered
- ACK_I  in  1  mentor acknowledge
- IDX_O  out  AW  index of the next entry to emit
- BUSY_O  out  1  high while STB_O is high
- DONE_O  out  1  one-cycle pulse when a one-shot pass completes
- OVR_O  out  1  sticky: a trigger arrived while a transfer was pending

## Operation
- Table: DEPTH×DATA_W registers, all zero at reset. A write lands at the clock edge. A write to the entry currently latched in DAT_O does not alter DAT_O.
- Trigger sources:
  - auto: a prescaler tick every PERIOD cycles.
  - manual: STEP_I high for a cycle.
  - one-shot: an immediate first trigger on entering mode 11 from any other mode, then a trigger after each ACK until the pass ends.
  - halt: no triggers. A pending transfer still completes.
- FSM states:
  - IDLE: on a trigger, latch DAT_O ← table[idx] and go to OFFER.
  - OFFER: STB_O=1. When ACK_I is sampled high, go to IDLE and set idx ← (idx+1 == len_eff) ? 0 : idx+1.
  - DONE: entered from OFFER in one-shot mode when the acked entry was len_eff−1. DONE_O pulses on entry. The FSM stays in DONE until MODE_I ≠ 11, then returns to IDLE with idx=0.
- Prescaler: cleared whenever MODE_I ≠ 01. Counts 0..PERIOD−1 and ticks at PERIOD−1, so the first auto emission comes PERIOD cycles after entering auto.
- Trigger while in OFFER or DONE: dropped, and OVR_O is set. OVR_O clears only on reset or on entry into halt.
- LEN_I shrink: if idx ≥ len_eff at the moment of a trigger, idx is forced to 0 before the table read.
- Mode change during OFFER: the transfer completes normally; the new mode governs the next trigger.
- Simultaneous WE_I and trigger on the same address: the trigger reads the old value.

## Timing
- Reset values: STB_O=0, DAT_O=0, IDX_O=0, BUSY_O=0, DONE_O=0, OVR_O=0; FSM in IDLE; prescaler 0.
- Trigger-to-strobe latency: STB_O and DAT_O are registered 1 cycle after the trigger cycle.
- ACK_I is sampled on the clock edge. STB_O falls and IDX_O advances on the same edge that samples ACK_I=1.
- ACK_I may be high in the same cycle STB_O rises; it is honoured only while STB_O=1, so the minimum transfer is 1 cycle.
- A back-to-back trigger is accepted no earlier than the cycle after STB_O falls.
- An asynchronous reset asserted mid-OFFER drops STB_O immediately; the transfer is lost.

## Structure
- Shared package prewish_pkg holds the MODE_* constants (HALT=2'b00, AUTO=2'b01, STEP=2'b10, ONCE=2'b11) and the FSM state encodings (IDLE, OFFER, DONE).
- One sub-module, prewish_prescaler: parametrised modulo-PERIOD counter with a synchronous clear and a one-cycle tick output. Table, FSM and index logic live in the top.

## Test plan
- Auto, PERIOD=8, LEN_I=3, table {0x80,0xA0,0xA8}, ACK_I tied high → STB_O pulses at cycles 9, 17, 25, 33 with DAT_O 0x80, 0xA0, 0xA8, 0x80.
- Manual, ACK_I delayed 5 cycles, a second STEP_I sent 2 cycles after the first → one transfer, STB_O held for 5 cycles, OVR_O=1, IDX_O=1 afterwards.
- One-shot, LEN_I=2, table {0xFF,0xD4} → two transfers, DONE_O pulses once, nothing further until MODE_I goes 00 then 11, after which 0xFF is emitted again.
- LEN_I changed 8→2 while IDX_O=5, then STEP_I → DAT_O=table[0], IDX_O=1.
- RST_I pulled low while in OFFER → STB_O=0 immediately and all outputs hold their reset values; after release, all table entries read 0.
- WE_I to ADR_I=0 in the same cycle as a trigger with idx=0 → DAT_O carries the old entry 0, and the next pass emits the new value.
